// File: rtl/ft_reg_bridge.sv
// ft_reg_bridge
// Sits behind the FT245-style USB FIFO bridge in the system clk domain.
// Unpacks the bridge's 16-bit receive words (with per-byte enables) into a
// byte stream and parses register command packets from it:
//   write: A5, addr, data[7:0], data[15:8]  -> one reg_we pulse
//   read : 5A, addr                         -> reg_re pulse, then one response
//                                              word pushed to the transmit side
// Any other opcode byte is dropped and counted in err_count, as are reads
// whose reg_rvalid never arrives (answered with ERR_DATA instead).
//
// Ports:
//   clk, rst                  clock, synchronous active-low reset
//   in_data/in_be/in_empty    first-word-fall-through receive word, byte enables, empty
//   in_get                    pop of the receive word (captured in the same cycle)
//   out_data/out_be/out_valid response word, byte enables, push strobe
//   out_full                  transmit FIFO full
//   reg_addr/reg_wdata        register bus address and write data
//   reg_we/reg_re             one-cycle write / read strobes
//   reg_rdata/reg_rvalid      read data returned some cycles after reg_re
//   err_count                 saturating count of bad opcodes and read timeouts
module ft_reg_bridge #(
  parameter int          ADDR_W   = 8,
  parameter logic [15:0] TIMEOUT  = 16'd1024,
  parameter logic [15:0] ERR_DATA = 16'hDEAD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       in_data,
  input  logic [1:0]        in_be,
  input  logic              in_empty,
  output logic              in_get,
  output logic [15:0]       out_data,
  output logic [1:0]        out_be,
  output logic              out_valid,
  input  logic              out_full,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [15:0]       reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [15:0]       reg_rdata,
  input  logic              reg_rvalid,
  output logic [7:0]        err_count
);

  typedef enum logic [3:0] {
    IDLE, W_ADDR, W_D0, W_D1, WRITE, R_ADDR, READ, R_WAIT, RESP
  } state_t;

  state_t      state, state_next;
  logic [15:0] word_q;
  logic [1:0]  mask_q, mask_next;
  logic [15:0] tmo_cnt;
  logic        byte_avail, accepting, consume, tmo_hit, err_opcode;
  logic        we_c, re_c, valid_c;
  logic [7:0]  cur_byte;

  // Lower lane is always presented first; the upper lane only once bit0 is gone.
  assign byte_avail = (mask_q != 2'b00);
  assign cur_byte   = mask_q[0] ? word_q[7:0] : word_q[15:8];
  assign consume    = byte_avail && accepting;
  assign tmo_hit    = (tmo_cnt == TIMEOUT - 16'd1);

  // Clearing the consumed lane here lets a new word be popped in the same
  // cycle the last pending byte of the held word is taken.
  always_comb begin
    mask_next = mask_q;
    if (consume) begin
      mask_next = mask_q[0] ? {mask_q[1], 1'b0} : 2'b00;
    end
  end

  // Popping is suppressed while reset is asserted so no word is lost into a
  // register that is about to be cleared.
  assign in_get = rst && (mask_next == 2'b00) && !in_empty;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Packet parser: next state, byte acceptance and the bus/transmit strobes.
  always_comb begin
    state_next = state;
    accepting  = 1'b0;
    err_opcode = 1'b0;
    we_c       = 1'b0;
    re_c       = 1'b0;
    valid_c    = 1'b0;
    case (state)
      IDLE: begin
        accepting = 1'b1;
        if (byte_avail) begin
          if (cur_byte == 8'hA5) begin
            state_next = W_ADDR;
          end else if (cur_byte == 8'h5A) begin
            state_next = R_ADDR;
          end else begin
            err_opcode = 1'b1;
          end
        end
      end
      W_ADDR: begin
        accepting = 1'b1;
        if (byte_avail) state_next = W_D0;
      end
      W_D0: begin
        accepting = 1'b1;
        if (byte_avail) state_next = W_D1;
      end
      W_D1: begin
        accepting = 1'b1;
        if (byte_avail) state_next = WRITE;
      end
      WRITE: begin
        we_c       = 1'b1;
        state_next = IDLE;
      end
      R_ADDR: begin
        accepting = 1'b1;
        if (byte_avail) state_next = READ;
      end
      READ: begin
        re_c       = 1'b1;
        state_next = R_WAIT;
      end
      R_WAIT: begin
        if (reg_rvalid || tmo_hit) state_next = RESP;
      end
      RESP: begin
        if (!out_full) begin
          valid_c    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Strobes are masked during reset so a half-finished packet can never
  // produce a bus cycle.
  assign reg_we    = rst && we_c;
  assign reg_re    = rst && re_c;
  assign out_valid = rst && valid_c;
  assign out_be    = out_valid ? 2'b11 : 2'b00;

  // Datapath: held receive word, captured packet fields, read wait counter,
  // response data and the error counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      word_q    <= 16'h0000;
      mask_q    <= 2'b00;
      reg_addr  <= '0;
      reg_wdata <= 16'h0000;
      tmo_cnt   <= 16'h0000;
      out_data  <= 16'h0000;
      err_count <= 8'h00;
    end else begin
      if (in_get) begin
        word_q <= in_data;
        mask_q <= in_be;
      end else begin
        mask_q <= mask_next;
      end

      case (state)
        W_ADDR, R_ADDR: if (consume) reg_addr <= cur_byte[ADDR_W-1:0];
        W_D0:           if (consume) reg_wdata[7:0]  <= cur_byte;
        W_D1:           if (consume) reg_wdata[15:8] <= cur_byte;
        READ:           tmo_cnt <= 16'h0000;
        R_WAIT: begin
          // Valid data takes priority over a timeout landing in the same cycle.
          if (reg_rvalid) begin
            out_data <= reg_rdata;
          end else if (tmo_hit) begin
            out_data <= ERR_DATA;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        default: ;
      endcase

      if ((err_opcode || (state == R_WAIT && !reg_rvalid && tmo_hit)) &&
          (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: doc/ft_reg_bridge.md
Name: ft_reg_bridge

Overview:
- Sits directly downstream of the FT245-style USB FIFO bridge, in the system `clk` domain.
- Consumes the bridge's receive word stream (16-bit words with per-byte enables) and unpacks it into bytes.
- Parses byte-level register read/write command packets and drives a simple internal register bus.
- Pushes read responses back into the bridge's transmit side.

Parameters:
- ADDR_W, 8, register address width; must be 8, since exactly one address byte is carried per packet.
- TIMEOUT, 16'd1024, max cycles to wait for reg_rvalid after reg_re before a timeout response.
- ERR_DATA, 16'hDEAD, data returned on read timeout.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-low reset; rst=0 at a clk edge resets all state.
- in_data  in  16  receive word from bridge (first-word-fall-through; valid while in_empty=0).
- in_be  in  2  byte enables for in_data; bit0 = [7:0], bit1 = [15:8].
- in_empty  in  1  receive FIFO empty.
- in_get  out  1  pop receive word; the word is captured in the same cycle.
- out_data  out  16  response word to bridge transmit.
- out_be  out  2  response byte enables; always 2'b11 when out_valid=1.
- out_valid  out  1  push response word.
- out_full  in  1  transmit FIFO full.
- reg_addr  out  8  register address.
- reg_wdata  out  16  register write data.
- reg_we  out  1  one-cycle write strobe.
- reg_re  out  1  one-cycle read strobe.
- reg_rdata  in  16  read data, sampled when reg_rvalid=1.
- reg_rvalid  in  1  read data valid; any cycle ≥1 after reg_re.
- err_count  out  8  saturating count of bad opcodes plus read timeouts.

Behaviour:
- Reset values: in_get=0, out_valid=0, out_data=0, out_be=0, reg_we=0, reg_re=0, reg_addr=0, reg_wdata=0, err_count=0; FSM=IDLE; unpacker mask=00; timeout counter=0.
- Unpacker: holds a word register and a 2-bit pending mask.
  - When mask==00 and in_empty==0: assert in_get for 1 cycle, load word, mask<=in_be.
  - A word with in_be==00 is popped and discarded.
  - Byte available when mask!=00. Lower lane is presented first (bit0 before bit1).
  - A byte is consumed (its mask bit cleared) only when the FSM is in a byte-accepting state. Max 1 byte/cycle.
  - A pop may occur in the same cycle the last pending byte is consumed: combinational mask-next==00.
- FSM states, byte-accepting unless noted:
  - IDLE: read opcode.
    - 8'hA5 -> W_ADDR.
    - 8'h5A -> R_ADDR.
    - Any other value -> stay IDLE, err_count+1.
  - W_ADDR: byte -> reg_addr; go to W_D0.
  - W_D0: byte -> reg_wdata[7:0]; go to W_D1.
  - W_D1: byte -> reg_wdata[15:8]; go to WRITE.
  - WRITE (non-accepting): reg_we=1 for exactly 1 cycle; go to IDLE.
  - R_ADDR: byte -> reg_addr; go to READ.
  - READ (non-accepting): reg_re=1 for exactly 1 cycle; clear timeout counter; go to R_WAIT.
  - R_WAIT (non-accepting):
    - reg_rvalid=1 -> latch reg_rdata into out_data; go to RESP.
    - Otherwise the counter increments. Counter reaching TIMEOUT-1 without rvalid -> out_data<=ERR_DATA, err_count+1, go to RESP.
    - A reg_rvalid arriving in the same cycle the counter hits TIMEOUT-1 wins: it is valid data, no error is counted.
  - RESP (non-accepting):
    - out_full==0 -> out_valid=1, out_be=2'b11 for 1 cycle; go to IDLE.
    - out_full==1 -> hold, out_valid=0.
- Latency:
  - Last write data byte consumed at cycle N -> reg_we at cycle N+1.
  - Address byte consumed at cycle N -> reg_re at N+1.
  - reg_rvalid at M with out_full=0 -> out_valid at M+1.
- Ignored strobes: reg_rvalid outside R_WAIT is ignored.
- Saturation: err_count saturates at 8'hFF.
- Framing across words: packet boundaries are independent of word boundaries. A packet may span any number of words; odd-byte words (be=01 or 10) are handled.
- Reset mid-operation: a reset mid-packet discards the partial packet and the held word. No strobe is emitted during or after reset until a new packet is complete.

Test Plan:
- Aligned write: words {be=11, 16'h10A5}, {be=11, 16'h3412} -> one reg_we pulse with reg_addr=8'h10, reg_wdata=16'h3412; exactly 2 in_get pulses.
- Single-byte-lane write: 4 words be=01 carrying A5,20,CD,AB -> reg_addr=8'h20, reg_wdata=16'hABCD, one reg_we; then a be=10 word 16'h5A00 followed by be=01 16'h0020 -> reg_re with reg_addr=8'h20.
- Read with backpressure: read addr 8'h07; reg_rdata=16'hBEEF with rvalid 3 cycles after reg_re; out_full=1 for 5 cycles -> out_valid only after out_full drops, out_data=16'hBEEF, out_be=2'b11.
- Timeout: read addr 8'h08 with no rvalid, TIMEOUT=16 -> out_data=16'hDEAD, err_count=1; a late rvalid afterwards has no effect.
- Bad opcode + recovery: byte stream FF,A5,01,02,03 -> err_count=1, then reg_we with addr 8'h01, wdata 16'h0302; a be=00 word anywhere is consumed and ignored.
- Reset mid-packet: A5,10 then rst=0 for 1 cycle, then 5A,10 -> no reg_we ever, one reg_re addr 8'h10, err_count=0.
